// File: rtl/stable_timer_pkg.sv
// stable_timer_pkg: shared TCFG/TICLR field positions, default widths and timer op encoding
package stable_timer_pkg;
    localparam int TCFG_EN          = 0;
    localparam int TCFG_PERIODIC    = 1;
    localparam int TCFG_INITVAL_LSB = 2;
    localparam int TICLR_CLR        = 0;
    localparam int DEF_CNT_WIDTH    = 64;
    localparam int DEF_TIMER_WIDTH  = 32;
    localparam int DEF_PRESCALE     = 1;
    typedef enum logic [1:0] {TV_HOLD, TV_LOAD, TV_DEC, TV_RELOAD} tval_op_e;
endpackage

// File: rtl/stable_timer_prescaler.sv
// stable_timer_prescaler: divides clk into a one-cycle tick every PRESCALE cycles
module stable_timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [W-1:0] pre_q, pre_d;
    always_comb begin
        tick  = pre_q == W'(PRESCALE - 1);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
endmodule

// File: rtl/stable_timer.sv
// stable_timer: stable counter plus TCFG/TVAL countdown timer; STABLE_TIMER_SNAPSHOT_EN adds a cnt_snap capture register
module stable_timer
    import stable_timer_pkg::*;
#(
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int TIMER_WIDTH = DEF_TIMER_WIDTH,
    parameter int PRESCALE    = DEF_PRESCALE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tcfg_we,
    input  logic [TIMER_WIDTH-1:0] tcfg_wdata,
    input  logic                   ticlr_we,
    input  logic                   ticlr_wdata,
    input  logic                   snap_req,
    output logic [CNT_WIDTH-1:0]   cnt,
    output logic [CNT_WIDTH-1:0]   cnt_snap,
    output logic [TIMER_WIDTH-1:0] tcfg,
    output logic [TIMER_WIDTH-1:0] tval,
    output logic                   timer_int
);
    logic                   tick;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [TIMER_WIDTH-1:0] tcfg_q, tcfg_d, tval_q, tval_d, load_val;
    logic                   int_q, int_d, fire;
    tval_op_e               op;

    stable_timer_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // A TCFG write owns tval for its cycle, so a coincident tick neither counts nor fires.
    always_comb begin
        load_val = {tcfg_q[TIMER_WIDTH-1:TCFG_INITVAL_LSB], 2'b00};
        op       = tcfg_we ? TV_LOAD
                 : !(tick && tcfg_q[TCFG_EN]) ? TV_HOLD
                 : tval_q != '0 ? TV_DEC
                 : tcfg_q[TCFG_PERIODIC] ? TV_RELOAD : TV_HOLD;
        tval_d   = op == TV_LOAD   ? {tcfg_wdata[TIMER_WIDTH-1:TCFG_INITVAL_LSB], 2'b00}
                 : op == TV_DEC    ? tval_q - 1'b1
                 : op == TV_RELOAD ? load_val : tval_q;
        fire     = op == TV_DEC && tval_q == TIMER_WIDTH'(1);
        int_d    = fire | (int_q & ~(ticlr_we & ticlr_wdata));
        tcfg_d   = tcfg_we ? tcfg_wdata : tcfg_q;
        cnt_d    = cnt_q + CNT_WIDTH'(tick);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt_q  <= '0;
            tcfg_q <= '0;
            tval_q <= '0;
            int_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            int_q  <= int_d;
        end

`ifdef STABLE_TIMER_SNAPSHOT_EN
    logic [CNT_WIDTH-1:0] snap_q, snap_d;
    always_comb snap_d = snap_req ? cnt_q : snap_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) snap_q <= '0;
        else     snap_q <= snap_d;
    assign cnt_snap = snap_q;
`else
    logic snap_unused;
    assign snap_unused = snap_req;
    assign cnt_snap    = cnt_q;
`endif

    assign cnt       = cnt_q;
    assign tcfg      = tcfg_q;
    assign tval      = tval_q;
    assign timer_int = int_q;
endmodule

// File: tb/tb_stable_timer.sv
// tb_stable_timer: directed checks of counter, prescale, wrap, one-shot, periodic, clear race, snapshot and async reset
module tb_stable_timer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        tcfg_we = 1'b0, ticlr_we = 1'b0, ticlr_wdata = 1'b0, snap_req = 1'b0;
    logic [31:0] tcfg_wdata = '0;
    logic [63:0] cnt, cnt_snap, cnt_p4, snap_p4;
    logic [7:0]  cnt_s, snap_s;
    logic [31:0] tcfg, tval, tcfg_p4, tval_p4, tcfg_s, tval_s;
    logic        timer_int, int_p4, int_s;
    int          n_checks = 0, n_fail = 0;
    longint      cyc = 0;

    always #5 clk = ~clk;

    stable_timer dut (
        .clk(clk), .rst(rst), .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
        .ticlr_we(ticlr_we), .ticlr_wdata(ticlr_wdata), .snap_req(snap_req),
        .cnt(cnt), .cnt_snap(cnt_snap), .tcfg(tcfg), .tval(tval), .timer_int(timer_int));

    stable_timer #(.PRESCALE(4)) dut_p4 (
        .clk(clk), .rst(rst), .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
        .ticlr_we(ticlr_we), .ticlr_wdata(ticlr_wdata), .snap_req(snap_req),
        .cnt(cnt_p4), .cnt_snap(snap_p4), .tcfg(tcfg_p4), .tval(tval_p4), .timer_int(int_p4));

    stable_timer #(.CNT_WIDTH(8)) dut_s (
        .clk(clk), .rst(rst), .tcfg_we(tcfg_we), .tcfg_wdata(tcfg_wdata),
        .ticlr_we(ticlr_we), .ticlr_wdata(ticlr_wdata), .snap_req(snap_req),
        .cnt(cnt_s), .cnt_snap(snap_s), .tcfg(tcfg_s), .tval(tval_s), .timer_int(int_s));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst) cyc++;
    endtask

    task automatic write_tcfg(input logic [31:0] v);
        tcfg_we    = 1'b1;
        tcfg_wdata = v;
        step();
        tcfg_we    = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        check("rst_cnt", cnt, 0);
        check("rst_tcfg", tcfg, 0);
        check("rst_tval", tval, 0);
        check("rst_int", {63'd0, timer_int}, 0);
        rst = 1'b0;
        repeat (20) step();
        check("cnt_20", cnt, 20);
        check("p4_cnt_20", cnt_p4, 5);
        check("small_cnt_20", {56'd0, cnt_s}, 20);
        repeat (236) step();
        check("small_wrap", {56'd0, cnt_s}, 0);
        check("cnt_256", cnt, 256);
        check("p4_cnt_256", cnt_p4, 64);
`ifdef STABLE_TIMER_SNAPSHOT_EN
        check("snap_idle", cnt_snap, 0);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        check("snap_cap", cnt_snap, 256);
        repeat (3) step();
        check("snap_hold", cnt_snap, 256);
        check("snap_cnt_moves", cnt, 260);
`else
        check("snap_track0", cnt_snap, 256);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        check("snap_track1", cnt_snap, 257);
        repeat (3) step();
        check("snap_track2", cnt_snap, 260);
`endif
        check("cnt_model", cnt, 64'(cyc));
        // one-shot, L = 8
        write_tcfg(32'h9);
        check("os_tcfg", tcfg, 32'h9);
        check("os_tval_load", tval, 8);
        repeat (7) step();
        check("os_tval_1", tval, 1);
        check("os_int_early", {63'd0, timer_int}, 0);
        step();
        check("os_tval_0", tval, 0);
        check("os_int_fire", {63'd0, timer_int}, 1);
        ticlr_we = 1'b1; ticlr_wdata = 1'b1;
        step();
        ticlr_we = 1'b0; ticlr_wdata = 1'b0;
        check("os_clear", {63'd0, timer_int}, 0);
        for (int i = 0; i < 50; i++) begin
            step();
            check("os_no_refire", {31'd0, timer_int, tval}, 0);
        end
        // periodic, L = 4, cleared every time it rises
        write_tcfg(32'h7);
        check("per_load", tval, 4);
        for (int i = 1; i <= 15; i++) begin
            step();
            check("per_tval", tval, 64'(4 - (i % 5)));
            check("per_int", {63'd0, timer_int}, (i % 5 == 4) ? 1 : 0);
            ticlr_we    = (i % 5 == 4);
            ticlr_wdata = (i % 5 == 4);
        end
        // clear coinciding with the 1->0 edge loses to the set
        repeat (3) step();
        check("race_tval_1", tval, 1);
        ticlr_we = 1'b1; ticlr_wdata = 1'b1;
        step();
        check("race_set_wins", {63'd0, timer_int}, 1);
        step();
        check("race_clear_next", {63'd0, timer_int}, 0);
        ticlr_we = 1'b0; ticlr_wdata = 1'b0;
        // ticlr with wdata=0 does not clear; tcfg write does not clear
        repeat (4) step();
        check("int_again", {63'd0, timer_int}, 1);
        ticlr_we = 1'b1;
        step();
        ticlr_we = 1'b0;
        check("ticlr_wdata0", {63'd0, timer_int}, 1);
        write_tcfg(32'h10);
        check("tcfg_keeps_int", {63'd0, timer_int}, 1);
        check("dis_load", tval, 16);
        repeat (5) step();
        check("dis_frozen", tval, 16);
        ticlr_we = 1'b1; ticlr_wdata = 1'b1;
        step();
        ticlr_we = 1'b0; ticlr_wdata = 1'b0;
        write_tcfg(32'h3);
        repeat (10) step();
        check("l0_never_fires", {31'd0, timer_int, tval}, 0);
        // asynchronous reset mid-countdown
        write_tcfg(32'h7);
        repeat (2) step();
        check("pre_rst_tval", tval, 2);
        #2 rst = 1'b1;
        #1;
        check("arst_cnt", cnt, 0);
        check("arst_snap", cnt_snap, 0);
        check("arst_p4", cnt_p4, 0);
        check("arst_tcfg", tcfg, 0);
        check("arst_tval", tval, 0);
        check("arst_int", {63'd0, timer_int}, 0);
        step();
        rst = 1'b0;
        repeat (10) step();
        check("post_rst_idle", {31'd0, timer_int, tval}, 0);
        check("post_rst_cnt", cnt, 10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
